// File: rtl/ram_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single RAM command port.
// Round-robin on ties, one outstanding RAM transaction at a time, and
// saturating per-requester stall counters.
module ram_arbiter #(
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,

   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_wmask,
   output logic              mem_gnt,
   output logic              mem_rvalid,
   output logic [63:0]       mem_rdata,

   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [63:0]       ram_wdata,
   output logic [63:0]       ram_wmask,
   input  logic              ram_ready,
   input  logic              ram_rvalid,
   input  logic [63:0]       ram_rdata,

   output logic [31:0]       if_stall_cnt,
   output logic [31:0]       mem_stall_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RESP
   } state_t;

   state_t            state_q;
   state_t            state_d;

   // owner_q / last_q: 1 = MEM, 0 = IF
   logic              owner_q;
   logic              last_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [63:0]       wdata_q;
   logic [63:0]       wmask_q;
   logic              any_gnt;
   logic              resp_done;

   assign any_gnt   = if_gnt | mem_gnt;
   assign resp_done = (state_q == RESP) && ram_rvalid;

   // Arbitration and next-state; grants only in IDLE and never during reset
   always_comb begin
      state_d = state_q;
      if_gnt  = 1'b0;
      mem_gnt = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst) begin
               if (mem_req && (!if_req || !last_q)) begin
                  mem_gnt = 1'b1;
               end else if (if_req) begin
                  if_gnt = 1'b1;
               end
               if (if_req || mem_req) begin
                  state_d = CMD;
               end
            end
         end
         CMD: begin
            if (ram_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (ram_rvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM command is presented only while in CMD; write enable/mask only for MEM stores
   always_comb begin
      ram_req   = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wmask = '0;
      if (state_q == CMD) begin
         ram_req   = 1'b1;
         ram_we    = owner_q & we_q;
         ram_addr  = addr_q;
         ram_wdata = wdata_q;
         ram_wmask = (owner_q & we_q) ? wmask_q : '0;
      end
   end

   // State register, grant-time capture of the winning request, response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
      end else begin
         state_q    <= state_d;
         if_rvalid  <= 1'b0;
         mem_rvalid <= 1'b0;
         if (any_gnt) begin
            owner_q <= mem_gnt;
            last_q  <= mem_gnt;
            addr_q  <= mem_gnt ? mem_addr : if_addr;
            we_q    <= mem_gnt & mem_we;
            wdata_q <= mem_gnt ? mem_wdata : '0;
            wmask_q <= mem_gnt ? mem_wmask : '0;
         end
         if (resp_done) begin
            if (owner_q) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= we_q ? '0 : ram_rdata;
            end else begin
               if_rvalid <= 1'b1;
               if_rdata  <= addr_q[2] ? ram_rdata[63:32] : ram_rdata[31:0];
            end
         end
      end
   end

   // Saturating count of cycles each requester waited without a grant
   always_ff @(posedge clk) begin
      if (rst) begin
         if_stall_cnt  <= '0;
         mem_stall_cnt <= '0;
      end else begin
         if (if_req && !if_gnt && (if_stall_cnt != '1)) begin
            if_stall_cnt <= if_stall_cnt + 32'd1;
         end
         if (mem_req && !mem_gnt && (mem_stall_cnt != '1)) begin
            mem_stall_cnt <= mem_stall_cnt + 32'd1;
         end
      end
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, RAM/requester address width.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: if_req  in  1, if_addr  in  ADDR_W, fetch request and byte address.
REQ-005 SHALL have ports: if_gnt  out  1, if_rvalid  out  1, if_rdata  out  32, fetch accept, response strobe, instruction.
REQ-006 SHALL have ports: mem_req  in  1, mem_we  in  1, mem_addr  in  ADDR_W, mem_wdata  in  64, mem_wmask  in  64, load/store request.
REQ-007 SHALL have ports: mem_gnt  out  1, mem_rvalid  out  1, mem_rdata  out  64, data accept, completion strobe (reads and writes), load data.
REQ-008 SHALL have ports: ram_req  out  1, ram_we  out  1, ram_addr  out  ADDR_W, ram_wdata  out  64, ram_wmask  out  64, single RAM port command.
REQ-009 SHALL have ports: ram_ready  in  1, ram_rvalid  in  1, ram_rdata  in  64, RAM command accept, response strobe, read data.
REQ-010 SHALL have ports: if_stall_cnt  out  32, mem_stall_cnt  out  32, cycles each requester waited ungranted.

Function
REQ-011 SHALL implement FSM states IDLE, CMD (ram_req high, awaiting ram_ready), RESP (awaiting ram_rvalid).
REQ-012 SHALL, in IDLE with any request, assert exactly one gnt combinationally in that cycle, latch owner, addr, we, wdata, wmask, and enter CMD next cycle.
REQ-013 SHALL never assert if_gnt or mem_gnt outside IDLE, nor both in one cycle.
REQ-014 SHALL, with both requests in IDLE, grant the requester not granted last (round-robin); last-owner register resets to IF so MEM wins the first tie.
REQ-015 SHALL, with only one request in IDLE, grant it regardless of last owner.
REQ-016 Requesters SHALL hold req and fields stable until gnt; arbiter SHALL ignore requester inputs after the grant cycle until IDLE.
REQ-017 SHALL drive ram_req=1 and latched fields only in CMD; ram_we=0 and ram_wmask=0 for IF owner or MEM read; ram_wmask=latched mask for MEM write.
REQ-018 SHALL leave CMD for RESP on ram_ready=1; stay in CMD with stable command otherwise, no timeout.
REQ-019 SHALL, in RESP on ram_rvalid=1, return to IDLE next cycle and pulse owner's rvalid for exactly one cycle in that next cycle.
REQ-020 SHALL set if_rdata = latched if_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0], mem_rdata = ram_rdata (0 for writes), registered with the rvalid pulse, held until next response of that owner.
REQ-021 SHALL ignore ram_rvalid in IDLE and CMD (no output change).
REQ-022 SHALL allow a new grant in the same cycle the previous rvalid pulse is output; minimum 3 cycles grant-to-grant with ram_ready and ram_rvalid immediate.
REQ-023 SHALL increment if_stall_cnt (mem_stall_cnt) each cycle if_req (mem_req)=1 and its gnt=0, saturating at 0xFFFF_FFFF without wrap.

Reset
REQ-024 SHALL on rst=1 at a clock edge force IDLE, last owner IF, all outputs 0 (gnt, rvalid, rdata, ram_*, stall counters), discarding any outstanding transaction.
REQ-025 SHALL treat ram_rvalid arriving after reset for a discarded transaction as spurious per REQ-021.
REQ-026 SHALL assert no gnt in a cycle where rst=1.

Verification
REQ-027 Fetch only: if_req=1, if_addr=0x8000_0004, ram_ready=1 immediately, ram_rvalid one cycle later with ram_rdata=0x1111_2222_3333_4444 -> if_gnt cycle 0, ram_req cycle 1, if_rvalid cycle 3 with if_rdata=0x1111_2222.
REQ-028 Tie: if_req=mem_req=1 continuously from reset -> grants MEM, IF, MEM, IF in order; if_stall_cnt=3 at second grant cycle.
REQ-029 Store: mem_we=1, mem_wmask=0x0000_0000_FFFF_FFFF, ram_ready held 0 for 4 cycles -> ram_req held 4 cycles with stable fields, ram_wmask matches, mem_rvalid pulses once, mem_rdata=0.
REQ-030 Reset in RESP: rst pulsed one cycle, then ram_rvalid=1 -> no rvalid pulse, state IDLE, counters 0, next if_req granted same cycle.
REQ-031 Saturation: preload-by-stall mem_req=1 with RAM never ready for 2^32+5 cycles (or forced counter 0xFFFF_FFFE) -> mem_stall_cnt stops at 0xFFFF_FFFF.
REQ-032 Spurious: ram_rvalid=1 in IDLE with no requests -> if_rvalid=mem_rvalid=0, rdata unchanged.
